// File: rtl/multi_port_wsel_decoder_pkg.sv
// Shared definitions for the multi-port write-select decoder: sizing helpers,
// fixed indices and parameter-legality checks.
package multi_port_wsel_decoder_pkg;

  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_NUM_WP   = 2;
  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned MAX_NUM_WP   = 4;
  localparam int unsigned PROT_REG     = 0;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Legal when the register count fits the address space and the port count is supported.
  function automatic bit cfg_ok(input int unsigned addr_w,
                                input int unsigned num_regs,
                                input int unsigned num_wp);
    return (num_regs >= 2) && (clog2(num_regs) <= addr_w) &&
           (num_wp >= 1) && (num_wp <= MAX_NUM_WP);
  endfunction

endpackage

// File: rtl/multi_port_wsel_decoder_if.sv
// Write-request / select-response bundle between the register-file front end
// and the write-select decoder.
interface multi_port_wsel_decoder_if
  import multi_port_wsel_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_WP   = DEF_NUM_WP,
  parameter int unsigned CNT_W    = DEF_CNT_W
);

  logic [NUM_WP*ADDR_W-1:0]   WAdd;
  logic [NUM_WP-1:0]          WEn;
  logic                       ClrDirty;
  logic [NUM_WP*NUM_REGS-1:0] PortSel;
  logic [NUM_REGS-1:0]        Sel;
  logic                       Conflict;
  logic                       OorErr;
  logic [CNT_W-1:0]           ConflictCnt;
  logic [CNT_W-1:0]           OorCnt;
  logic [NUM_REGS-1:0]        Dirty;

  modport master (
    output WAdd, WEn, ClrDirty,
    input  PortSel, Sel, Conflict, OorErr, ConflictCnt, OorCnt, Dirty
  );

  modport slave (
    input  WAdd, WEn, ClrDirty,
    output PortSel, Sel, Conflict, OorErr, ConflictCnt, OorCnt, Dirty
  );

endinterface

// File: rtl/multi_port_wsel_decoder_onehot_dec.sv
// Single-port address decoder: one-hot select for in-range enabled addresses,
// plus an out-of-range indication.
module onehot_dec #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                oor
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && (addr == ADDR_W'(i))) onehot[i] = 1'b1;
    end
  end

  // Extra bit so NUM_REGS == 2**ADDR_W is representable and never flags.
  assign oor = en && ({1'b0, addr} >= (ADDR_W+1)'(NUM_REGS));

endmodule

// File: rtl/multi_port_wsel_decoder.sv
// Registered multi-port write-select decoder with priority arbitration,
// register-0 protection, range checking, event counters and dirty scoreboard.
module multi_port_wsel_decoder
  import multi_port_wsel_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
  parameter int unsigned NUM_WP       = DEF_NUM_WP,
  parameter int unsigned ZERO_PROTECT = 1,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input logic                    Clk,
  input logic                    Rst,
  multi_port_wsel_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  if (!cfg_ok(ADDR_W, NUM_REGS, NUM_WP)) begin : g_bad_cfg
    $error("multi_port_wsel_decoder: illegal ADDR_W/NUM_REGS/NUM_WP combination");
  end

  logic [NUM_REGS-1:0]        dec_oh [NUM_WP];
  logic [NUM_WP-1:0]          dec_oor;
  logic [NUM_REGS-1:0]        valid_c;
  logic [NUM_REGS-1:0]        claimed_c;
  logic [NUM_WP*NUM_REGS-1:0] port_sel_c;
  logic                       conflict_c;
  logic                       oor_c;

  for (genvar p = 0; p < NUM_WP; p++) begin : g_dec
    onehot_dec #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_dec (
      .addr   (bus.WAdd[p*ADDR_W +: ADDR_W]),
      .en     (bus.WEn[p]),
      .onehot (dec_oh[p]),
      .oor    (dec_oor[p])
    );
  end

  // Lower ports claim registers first; a later port hitting a claimed register loses.
  always_comb begin
    valid_c    = '0;
    claimed_c  = '0;
    port_sel_c = '0;
    conflict_c = 1'b0;
    oor_c      = |dec_oor;
    for (int unsigned p = 0; p < NUM_WP; p++) begin
      valid_c = dec_oh[p];
      if (ZERO_PROTECT != 0) valid_c[PROT_REG] = 1'b0;
      if (|(valid_c & claimed_c)) conflict_c = 1'b1;
      port_sel_c[p*NUM_REGS +: NUM_REGS] = valid_c & ~claimed_c;
      claimed_c = claimed_c | valid_c;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bus.PortSel     <= '0;
      bus.Sel         <= '0;
      bus.Conflict    <= 1'b0;
      bus.OorErr      <= 1'b0;
      bus.ConflictCnt <= '0;
      bus.OorCnt      <= '0;
      bus.Dirty       <= '0;
    end else begin
      bus.PortSel  <= port_sel_c;
      bus.Sel      <= claimed_c;
      bus.Conflict <= conflict_c;
      bus.OorErr   <= oor_c;
      if (conflict_c && (bus.ConflictCnt != CNT_SAT)) bus.ConflictCnt <= bus.ConflictCnt + 1'b1;
      if (oor_c && (bus.OorCnt != CNT_SAT))           bus.OorCnt      <= bus.OorCnt + 1'b1;
      // A write landing with a clear survives the clear.
      bus.Dirty <= (bus.ClrDirty ? '0 : bus.Dirty) | claimed_c;
    end
  end

endmodule

// File: doc/multi_port_wsel_decoder.md
Name: multi_port_wsel_decoder

Overview:
- Parametrised, registered write-select decoder for the register file.
- Accepts NUM_WP independent write ports. Each port has an address and an enable.
- Produces registered one-hot selects, both per port and combined, one cycle after the request.
- Adds four behaviours: same-address collision arbitration, register-0 write protection, out-of-range rejection, and a per-register dirty scoreboard with saturating event counters.

Parameters:
- ADDR_W, 5, write-address width per port.
- NUM_REGS, 32, registers decoded. Must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- NUM_WP, 2, number of write ports (1..4). Port 0 has the highest priority.
- ZERO_PROTECT, 1, when 1, writes to register 0 are silently dropped.
- CNT_W, 8, width of the saturating event counters.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- WAdd  in  NUM_WP*ADDR_W  packed write addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- WEn  in  NUM_WP  per-port write enables.
- ClrDirty  in  1  synchronous clear of the dirty scoreboard.
- PortSel  out  NUM_WP*NUM_REGS  registered per-port one-hot select; port p occupies bits [p*NUM_REGS +: NUM_REGS].
- Sel  out  NUM_REGS  registered OR of all PortSel slices.
- Conflict  out  1  one-cycle pulse: at least one collision was dropped.
- OorErr  out  1  one-cycle pulse: at least one enabled port had an address >= NUM_REGS.
- ConflictCnt  out  CNT_W  saturating count of cycles with Conflict set.
- OorCnt  out  CNT_W  saturating count of cycles with OorErr set.
- Dirty  out  NUM_REGS  sticky per-register "written since last clear" bits.

Behaviour:
- Reset: Rst=1 asynchronously forces every output to zero: PortSel, Sel, Conflict, OorErr, ConflictCnt, OorCnt, Dirty.
- Reset mid-operation: the request in that cycle is lost. Decoding resumes on the first edge after Rst deasserts.
- Latency: request sampled at edge N; PortSel, Sel, flags, counters and Dirty all reflect it after edge N. There is no combinational path from inputs to outputs.
- Per-port decode: PortSel[p] = one-hot of WAdd[p] only if all of the following hold; otherwise the slice is zero:
  - WEn[p]=1;
  - WAdd[p] < NUM_REGS;
  - not (ZERO_PROTECT=1 and WAdd[p]=0);
  - no lower-index port q < p is also valid for the same address.
- Any WEn=0 cycle yields a zero slice the next cycle. Sel is all zeros when no port is valid.
- Collision:
  - Lowest index wins; each losing port's slice is zeroed.
  - Conflict=1 for one cycle if any port lost, regardless of how many ports collided.
  - Ports that were already dropped for out-of-range or zero-protect never count as colliding.
- Out of range: an enabled port with WAdd >= NUM_REGS is dropped and sets OorErr. With NUM_REGS = 2**ADDR_W, OorErr is never set.
- Zero protect: register-0 writes are dropped with no flag and no count. With ZERO_PROTECT=0, register 0 decodes like any other register.
- Invariants: Sel is a bitwise OR of mutually disjoint one-hot slices, so popcount(Sel) <= NUM_WP. No register is ever selected by two ports.
- Counters: increment by 1 in a cycle whose flag is set. They hold at 2**CNT_W-1 and never wrap. Only Rst clears them.
- Dirty:
  - Next value = (ClrDirty ? 0 : Dirty) | next Sel.
  - When a write coincides with ClrDirty, the write wins, so the new bits remain set.
  - Dropped writes never set Dirty.

Decomposition:
- Shared package/include:
  - function for the ceiling log2 of NUM_REGS;
  - localparams for the counter saturation value and the protected register index (0);
  - parameter-legality checks (elaboration error when NUM_REGS > 2**ADDR_W or NUM_WP is outside 1..4).
- Sub-module: onehot_dec. Combinational. Takes ADDR_W and NUM_REGS. Inputs are addr and en; outputs are onehot and oor. Instantiated once per port.
- Arbitration, flags, counters and Dirty stay in the top level.

Test Plan:
- Reset then idle: Rst pulse mid-cycle while WAdd[0]=7, WEn=01 -> all outputs 0 immediately. After release with WEn=00 -> Sel=0, counters stay 0.
- Single write: WEn=01, WAdd[0]=5 -> next cycle PortSel[0]=0x20, Sel=0x20, Dirty=0x20. Then WEn=00 -> Sel=0, Dirty still 0x20.
- Dual distinct write:
  - Stimulus: WEn=11, WAdd[0]=3, WAdd[1]=31.
  - Response: Sel=0x80000008, PortSel[1]=0x80000000, Conflict=0.
- Collision: WEn=11, both addresses 9 -> PortSel[0]=0x200, PortSel[1]=0, Conflict pulses once, ConflictCnt=1. Repeat 300 cycles -> ConflictCnt=255 and holds.
- Zero protect and range:
  - Stimulus 1: ZERO_PROTECT=1, WEn=01, WAdd[0]=0 -> Sel=0, Conflict=0, Dirty bit 0 stays 0.
  - Stimulus 2: NUM_REGS=24, WAdd[0]=30 -> Sel=0, OorErr=1, OorCnt=1.
- ClrDirty race: Dirty=0x20. ClrDirty=1 in the same cycle as WAdd[0]=2, WEn=01 -> Dirty=0x04.
